// File: rtl/calc_issue_stage.sv
// calc_issue_stage: issue stage in front of the combinational 64-bit calculator.
// Accepts one tagged request at a time over in_valid/in_ready, drives the
// registered operands onto calc_a/calc_b/calc_mode, waits SETTLE cycles, then
// captures calc_result with invalid-mode / divide-by-zero flags into an output
// FIFO presented on out_valid/out_ready/out_result/out_tag/out_err.
//   clk, rst_n       : clock, synchronous active-low reset
//   in_*             : request handshake, operands, mode, tag
//   calc_*           : registered calculator inputs and its combinational result
//   out_*            : FIFO head (zeroed when empty), err[0] bad mode, err[1] div by 0
module calc_issue_stage #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [3:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      calc_a,
  output logic [63:0]      calc_b,
  output logic [3:0]       calc_mode,
  input  logic [63:0]      calc_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state;
  logic [SET_W-1:0]   settle_cnt;
  logic [TAG_W-1:0]   tag_q;

  logic [63:0]        fifo_result [DEPTH];
  logic [TAG_W-1:0]   fifo_tag    [DEPTH];
  logic [1:0]         fifo_err    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               accept;
  logic               capture;
  logic               pop;
  logic [1:0]         cap_err;
  logic [63:0]        cap_result;

  always_comb begin
    in_ready   = rst_n && (state == IDLE) && (count < DEPTH_C);
    accept     = in_valid && in_ready;
    capture    = (state == EXEC) && (settle_cnt == SETTLE_LAST);
    out_valid  = (count != '0);
    pop        = out_valid && out_ready;
    cap_err    = '0;
    cap_err[0] = (calc_mode > 4'd3);
    cap_err[1] = (calc_mode == 4'd3) && (calc_b == '0);
    cap_result = (cap_err != '0) ? '0 : calc_result;
    out_result = out_valid ? fifo_result[rd_ptr] : '0;
    out_tag    = out_valid ? fifo_tag[rd_ptr]    : '0;
    out_err    = out_valid ? fifo_err[rd_ptr]    : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      tag_q      <= '0;
      calc_a     <= '0;
      calc_b     <= '0;
      calc_mode  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            calc_a     <= in_a;
            calc_b     <= in_b;
            calc_mode  <= in_mode;
            tag_q      <= in_tag;
            settle_cnt <= '0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (capture) state <= IDLE;
        end
      endcase

      if (capture) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;

      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (rst_n && capture) begin
      fifo_result[wr_ptr] <= cap_result;
      fifo_tag[wr_ptr]    <= tag_q;
      fifo_err[wr_ptr]    <= cap_err;
    end
  end

endmodule

// File: tb/tb_calc_issue_stage.sv
// Bench for calc_issue_stage: two instances (SETTLE=1 and SETTLE=4) share one
// stimulus stream; each is compared every cycle against a queue-based model.
module tb_calc_issue_stage;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  typedef struct packed {
    logic [63:0]      result;
    logic [TAG_W-1:0] tag;
    logic [1:0]       err;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid;
  logic [63:0]      in_a;
  logic [63:0]      in_b;
  logic [3:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready_w    [2];
  logic [63:0]      calc_a_w      [2];
  logic [63:0]      calc_b_w      [2];
  logic [3:0]       calc_mode_w   [2];
  logic [63:0]      calc_result_w [2];
  logic             out_valid_w   [2];
  logic [63:0]      out_result_w  [2];
  logic [TAG_W-1:0] out_tag_w     [2];
  logic [1:0]       out_err_w     [2];

  // Stand-in calculator; garbage on invalid modes so the forced zero is visible.
  function automatic logic [63:0] calc_fn(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] mode);
    case (mode)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      default: return 64'hDEAD_BEEF_0BAD_F00D ^ a;
    endcase
  endfunction

  assign calc_result_w[0] = calc_fn(calc_a_w[0], calc_b_w[0], calc_mode_w[0]);
  assign calc_result_w[1] = calc_fn(calc_a_w[1], calc_b_w[1], calc_mode_w[1]);

  calc_issue_stage #(.DEPTH(DEPTH), .SETTLE(1), .TAG_W(TAG_W)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .calc_a(calc_a_w[0]), .calc_b(calc_b_w[0]), .calc_mode(calc_mode_w[0]),
    .calc_result(calc_result_w[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_result(out_result_w[0]), .out_tag(out_tag_w[0]), .out_err(out_err_w[0])
  );

  calc_issue_stage #(.DEPTH(DEPTH), .SETTLE(4), .TAG_W(TAG_W)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .calc_a(calc_a_w[1]), .calc_b(calc_b_w[1]), .calc_mode(calc_mode_w[1]),
    .calc_result(calc_result_w[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_result(out_result_w[1]), .out_tag(out_tag_w[1]), .out_err(out_err_w[1])
  );

  // Reference model state, one slot per instance.
  int          settle_of [2] = '{1, 4};
  entry_t      mq        [2][$];
  int          busy      [2];
  entry_t      pend      [2];
  logic [63:0] m_a       [2];
  logic [63:0] m_b       [2];
  logic [3:0]  m_mode    [2];
  int          acc_cnt   [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic entry_t expect_entry(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] mode, input logic [TAG_W-1:0] tag);
    entry_t e;
    e.tag = tag;
    e.err = 2'b00;
    if (mode > 4'd3) e.err = 2'b01;
    else if (mode == 4'd3 && b == 64'd0) e.err = 2'b10;
    if (e.err != 2'b00) e.result = 64'd0;
    else if (mode == 4'd0) e.result = a + b;
    else if (mode == 4'd1) e.result = a - b;
    else if (mode == 4'd2) e.result = a * b;
    else e.result = a / b;
    return e;
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic   exp_rdy;
      entry_t head;
      exp_rdy = rst_n && (busy[i] == 0) && (mq[i].size() < DEPTH);
      head    = '0;
      if (mq[i].size() != 0) head = mq[i][0];
      check($sformatf("in_ready[%0d]", i),   64'(in_ready_w[i]),   64'(exp_rdy));
      check($sformatf("out_valid[%0d]", i),  64'(out_valid_w[i]),  64'(mq[i].size() != 0));
      check($sformatf("out_result[%0d]", i), out_result_w[i],      head.result);
      check($sformatf("out_tag[%0d]", i),    64'(out_tag_w[i]),    64'(head.tag));
      check($sformatf("out_err[%0d]", i),    64'(out_err_w[i]),    64'(head.err));
      check($sformatf("calc_a[%0d]", i),     calc_a_w[i],          m_a[i]);
      check($sformatf("calc_b[%0d]", i),     calc_b_w[i],          m_b[i]);
      check($sformatf("calc_mode[%0d]", i),  64'(calc_mode_w[i]),  64'(m_mode[i]));
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic rdy;
      if (!rst_n) begin
        mq[i].delete();
        busy[i]   = 0;
        m_a[i]    = '0;
        m_b[i]    = '0;
        m_mode[i] = '0;
      end else begin
        rdy = (busy[i] == 0) && (mq[i].size() < DEPTH);
        if (mq[i].size() != 0 && out_ready) void'(mq[i].pop_front());
        if (busy[i] > 0) begin
          busy[i]--;
          if (busy[i] == 0) mq[i].push_back(pend[i]);
        end
        if (rdy && in_valid) begin
          pend[i]   = expect_entry(in_a, in_b, in_mode, in_tag);
          busy[i]   = settle_of[i];
          m_a[i]    = in_a;
          m_b[i]    = in_b;
          m_mode[i] = in_mode;
          acc_cnt[i]++;
        end
      end
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 time unit later.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] mode, input logic [TAG_W-1:0] tag);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_tag   = tag;
  endtask

  task automatic one_request(input logic [63:0] a, input logic [63:0] b,
                             input logic [3:0] mode, input logic [TAG_W-1:0] tag);
    drive(1'b1, a, b, mode, tag);
    cycle();
    drive(1'b0, '0, '0, '0, '0);
    repeat (7) cycle();
  endtask

  initial begin
    int base;
    int k;
    logic fired;

    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; acc_cnt[i] = 0; m_a[i] = '0; m_b[i] = '0; m_mode[i] = '0; pend[i] = '0;
    end
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cycle();                         // reset cycle: in_ready/out_valid low, calc zero
    rst_n = 1'b1;

    // Single add, SETTLE=1 instance timing pinned to absolute values.
    drive(1'b1, 64'd5, 64'd7, 4'd0, 4'd3);
    cycle();
    drive(1'b0, '0, '0, '0, '0);
    #1 check("add_busy_in_ready", 64'(in_ready_w[0]), 64'd0);
    cycle();
    #1 check("add_out_valid", 64'(out_valid_w[0]), 64'd1);
    check("add_result", out_result_w[0], 64'd12);
    check("add_tag", 64'(out_tag_w[0]), 64'd3);
    check("add_err", 64'(out_err_w[0]), 64'd0);
    repeat (6) cycle();

    one_request(64'd100, 64'd0, 4'd3, 4'd4);
    one_request(64'd100, 64'd7, 4'd3, 4'd5);
    one_request(64'd1,   64'd1, 4'd9, 4'd6);
    one_request(64'd3,   64'd5, 4'd1, 4'd7);
    one_request(64'hFFFF_FFFF_0000_0003, 64'd3, 4'd2, 4'd8);

    // Back-pressure: six requests against a stalled consumer, then drain.
    base = acc_cnt[0];
    out_ready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      in_valid = (acc_cnt[0] - base) < 6;
      in_a     = 64'(c * 3 + 1);
      in_b     = 64'(c + 2);
      in_mode  = 4'(c % 4);
      in_tag   = TAG_W'(acc_cnt[0] - base);
      out_ready = (c >= 20);
      if (c == 19) check("bp_accepted_while_full", 64'(acc_cnt[0] - base), 64'd4);
      cycle();
    end
    check("bp_accepted_total", 64'(acc_cnt[0] - base), 64'd6);
    drive(1'b0, '0, '0, '0, '0);

    // FIFO at 3 with one in flight; pop on the push edge.
    base = acc_cnt[0];
    out_ready = 1'b0;
    fired = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (acc_cnt[0] - base) < 4;
      in_a      = 64'(c + 10);
      in_b      = 64'(c + 1);
      in_mode   = 4'd2;
      in_tag    = TAG_W'(c);
      out_ready = (busy[0] == 1 && mq[0].size() == 3) || (c > 30);
      if (busy[0] == 1 && mq[0].size() == 3) fired = 1'b1;
      cycle();
    end
    check("full_pushpop_reached", 64'(fired), 64'd1);
    drive(1'b0, '0, '0, '0, '0);
    out_ready = 1'b1;
    repeat (20) cycle();

    // Reset while the SETTLE=4 instance holds two entries and is mid-EXEC.
    out_ready = 1'b0;
    fired = 1'b0;
    k = 0;
    while (!fired && k < 100) begin
      in_valid = 1'b1;
      in_a     = 64'(k + 40);
      in_b     = 64'(k + 1);
      in_mode  = 4'd0;
      in_tag   = TAG_W'(k);
      if (mq[1].size() == 2 && busy[1] == 2) begin
        rst_n = 1'b0;
        fired = 1'b1;
      end
      cycle();
      k++;
    end
    check("midexec_reset_reached", 64'(fired), 64'd1);
    rst_n = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    out_ready = 1'b1;
    #1 check("post_reset_in_ready", 64'(in_ready_w[1]), 64'd1);
    check("post_reset_calc_a", calc_a_w[1], 64'd0);
    repeat (10) cycle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = {$urandom(), $urandom()};
      in_b      = ($urandom_range(0, 7) == 0) ? 64'd0 :
                  (($urandom_range(0, 1) == 0) ? 64'($urandom_range(1, 1000)) : {$urandom(), $urandom()});
      in_mode   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      in_tag    = TAG_W'($urandom());
      out_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    out_ready = 1'b1;
    repeat (20) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
